i2c_slave: RTL and testbench
============================

# i2c_slave

Register-addressed I2C target, the responder end for `i2c_master`. Sits on the shared SDA/SCL pins, recognises its 7-bit address, and accepts the same frame formats the master issues. Write frames are START, addr+W, register address, data, STOP; multi-word writes may be chained. Read frames are START, addr+W, register address, repeated START, addr+R, data, then NACK and STOP. Exposes a simple strobe interface to a local register file; no clock stretching.

## Interface
- `ADDR_BYTES`, 1: register-address bytes per frame (1–2).
- `DATA_BYTES`, 2: bytes per data word (1–4).
- `REG_ADDR_WIDTH`, 8*ADDR_BYTES: register address width.
- `clk` in 1: system clock, one clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: low forces idle and releases SDA. Synchronous.
- `own_addr` in 7: target address; quasi-static.
- `scl_in` in 1: SCL pin input, asynchronous.
- `sda_in` in 1: SDA pin input, asynchronous.
- `sda_out` out 1: constant 0, open-drain data.
- `sda_oen` out 1: 1 releases SDA, 0 pulls SDA low.
- `reg_addr` out REG_ADDR_WIDTH: current register address.
- `wr_data` out 8*DATA_BYTES: last completed write word, MSB first on the wire.
- `wr_valid` out 1: one-cycle pulse when `wr_data` and `reg_addr` are valid.
- `rd_req` out 1: one-cycle pulse requesting the word at `reg_addr`.
- `rd_data` in 8*DATA_BYTES: read word. Must be valid ≤2 clk after `rd_req` and held until the next `rd_req`.
- `busy` out 1: high from address match to STOP or START.
- `err` out 1: one-cycle pulse when STOP arrives mid-word.

## Operation
- **Input conditioning:** SCL and SDA each pass a 2-flop synchronizer plus a previous-value flop.
  - Edge detect: SCL rise and SCL fall.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing:** SDA is sampled on the detected SCL rise. `sda_oen` changes only on the detected SCL fall.
- **States:**
  - `s_idle`: wait for START.
  - `s_addr`: shift 8 bits. At the 8th bit, if bits[7:1]==own_addr, go to `s_addr_ack` and drive ACK. Otherwise go to `s_idle`.
  - `s_addr_ack`: on R/W=0 go to `s_reg`. On R/W=1, `rd_req` pulses at the ACK SCL rise, and the word is loaded into the shift register at the ACK SCL fall; go to `s_rd`.
  - `s_reg`: shift ADDR_BYTES bytes, ACKing each. After the last ACK, update `reg_addr`, then go to `s_wr`.
  - `s_wr`: shift DATA_BYTES bytes, ACKing each in `s_wr_ack`. After the last byte, pulse `wr_valid`, then `reg_addr` increments on the next clk. Continue in `s_wr` for chained words.
  - `s_rd`: drive MSB first, then release SDA for the master's ACK/NACK in `s_rd_ack`.
    - Master ACK within a word: continue.
    - Master ACK at the word end: increment `reg_addr` and pulse `rd_req` (loaded at the SCL fall).
    - Master NACK: go to `s_idle`, SDA released.
- **START in any state** (repeated START): go to `s_addr`, clear the bit count, discard the partial word (no `wr_valid`), and keep `reg_addr`.
- **STOP in any state:** go to `s_idle`, release SDA, clear `busy`. `err` pulses if any byte of the current word is partially received or not yet ACKed in `s_wr`.
- **Address rules:** `reg_addr` wraps from all-ones to 0. A read without a preceding address phase uses the retained `reg_addr`.
- **Reset values:** `sda_oen`=1, `sda_out`=0, `reg_addr`=0, `wr_data`=0, `wr_valid`=0, `rd_req`=0, `busy`=0, `err`=0, state `s_idle`.
- **Asynchronous reset mid-frame** releases SDA immediately.

## Timing
- Pin to detected edge: 3 clk.
- SDA drive changes 1 clk after the detected SCL fall, giving hold ≥1 clk.
- SCL high and low periods must each be ≥6 clk. The master with `clk_div`≥2 on the same clock satisfies this.
- `wr_valid` fires 1 clk after the SCL rise of the last data bit's ACK clock.
- `reg_addr` increments 1 clk after `wr_valid`.
- `rd_req` fires 1 clk after the relevant SCL rise. `rd_data` is sampled at the following SCL fall, ≥3 clk later.

## Structure
- Shared package `i2c_pkg`:
  - state encoding localparams for `i2c_slave`;
  - `ACK`/`NACK` bit constants;
  - `DATA_BYTES`/`ADDR_BYTES` defaults shared with `i2c_master`.
- Sub-module `i2c_bus_monitor`: synchronizers, SCL rise/fall, START/STOP detection. Reusable by the master for arbitration later.

## Test plan
All scenarios use own_addr=7'h50, ADDR_BYTES=1, DATA_BYTES=2, driven by `i2c_master` with clk_div=4.

- **Single write** of 0xBEEF to reg 0x12 → one `wr_valid` with `wr_data`=16'hBEEF, `reg_addr`=8'h12; all 4 bytes ACKed (master `status`=0); `reg_addr`=8'h13 after.
- **Read** of reg 0x20 with `rd_data`=16'hA55A after `rd_req` → exactly one `rd_req` with `reg_addr`=8'h20; master `data_out`=16'hA55A; SDA released after NACK; `busy` low after STOP.
- **Address mismatch:** write to 7'h51 → no ACK (master `status` bit set), `sda_oen` stays 1, no strobes.
- **Chained multi-word write** 0x0102, 0x0304 starting at reg 0xFF → `wr_valid` at `reg_addr` 0xFF then 0x00 (wrap).
- **STOP after first data byte** → `err` pulse, no `wr_valid`, state idle.
- **Reset asserted** during the address ACK low phase → `sda_oen`=1 in the same cycle; next frame is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target (and later the controller).
// Latency: n/a (constants only).
// Backpressure: n/a.
package i2c_pkg;

    // Frame-size defaults shared by i2c_slave and i2c_master
    localparam int DEF_ADDR_BYTES = 1;
    localparam int DEF_DATA_BYTES = 2;

    // Acknowledge bit values as seen on SDA
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // i2c_slave state encoding
    typedef logic [3:0] slv_state_t;
    localparam slv_state_t s_idle     = 4'd0;
    localparam slv_state_t s_addr     = 4'd1;
    localparam slv_state_t s_addr_ack = 4'd2;
    localparam slv_state_t s_reg      = 4'd3;
    localparam slv_state_t s_reg_ack  = 4'd4;
    localparam slv_state_t s_wr       = 4'd5;
    localparam slv_state_t s_wr_ack   = 4'd6;
    localparam slv_state_t s_rd       = 4'd7;
    localparam slv_state_t s_rd_ack   = 4'd8;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C pin conditioning: 2-flop synchronizers, SCL edge and START/STOP detect.
// Latency: 3 clk from pin change to event pulse.
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
// Ports: clk, reset (async active-low), scl_in/sda_in (raw pins),
//        sda (synchronised SDA aligned with the event pulses),
//        scl_rise, scl_fall, start_det, stop_det (one-cycle pulses).
module i2c_bus_monitor (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Synchronisers reset to 1 (idle bus) so reset release never looks like START
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[0], scl_in};
            sda_sync  <= {sda_sync[0], sda_in};
            scl_prev  <= scl_sync[1];
            sda_prev  <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_prev;
            scl_fall  <= ~scl_sync[1] & scl_prev;
            // SDA edges only count as START/STOP while SCL is stable high
            start_det <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
        end
    end

    // sda_prev lines up with the registered event pulses
    assign sda = sda_prev;

endmodule

// File: rtl/i2c_slave.sv
// Register-addressed I2C target with write/read strobes to a local register file.
// Latency: pins->event 3 clk; wr_valid/rd_req 1 clk after detected SCL rise; SDA 1 clk after detected fall.
// Backpressure: none (no clock stretching); rd_data must be valid within 2 clk of rd_req.
// Ports: clk, reset (async active-low), enable, own_addr, scl_in/sda_in (pins),
//        sda_out/sda_oen (open-drain SDA), reg_addr, wr_data/wr_valid, rd_req/rd_data, busy, err.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int ADDR_BYTES     = DEF_ADDR_BYTES,
    parameter int DATA_BYTES     = DEF_DATA_BYTES,
    parameter int REG_ADDR_WIDTH = 8*ADDR_BYTES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [6:0]                own_addr,
    input  logic                      scl_in,
    input  logic                      sda_in,
    output logic                      sda_out,
    output logic                      sda_oen,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [8*DATA_BYTES-1:0]   wr_data,
    output logic                      wr_valid,
    output logic                      rd_req,
    input  logic [8*DATA_BYTES-1:0]   rd_data,
    output logic                      busy,
    output logic                      err
);

    localparam int WW = 8*DATA_BYTES;

    slv_state_t state, state_nxt;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;
    logic [7:0] rx_sr;
    logic [WW-1:0] tx_sr, data_acc;
    logic [REG_ADDR_WIDTH-1:0] addr_acc;
    logic bit_seen, rw, mnack;

    logic bit_fall, byte_end, last_addr, last_data, addr_match, rx_state;
    logic sda_oen_nxt, wr_valid_nxt, rd_req_nxt, err_nxt, busy_nxt, load_word;

    i2c_bus_monitor u_mon (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda_out = 1'b0;

    // A fall only completes a bit if SCL rose since the last fall/START, so the
    // SCL fall right after START and the SCL rise before STOP are not counted.
    assign bit_fall   = scl_fall & bit_seen;
    assign byte_end   = bit_fall && (bit_cnt == 3'd7);
    assign last_addr  = (byte_cnt == 2'(ADDR_BYTES-1));
    assign last_data  = (byte_cnt == 2'(DATA_BYTES-1));
    assign addr_match = (rx_sr[7:1] == own_addr);
    assign rx_state   = (state == s_addr) || (state == s_reg) || (state == s_wr);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= s_idle;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!enable || stop_det) begin
            state_nxt = s_idle;
        end else if (start_det) begin
            state_nxt = s_addr;
        end else begin
            case (state)
                s_addr:     if (byte_end) state_nxt = addr_match ? s_addr_ack : s_idle;
                s_addr_ack: if (scl_fall) state_nxt = rw ? s_rd : s_reg;
                s_reg:      if (byte_end) state_nxt = s_reg_ack;
                s_reg_ack:  if (scl_fall) state_nxt = last_addr ? s_wr : s_reg;
                s_wr:       if (byte_end) state_nxt = s_wr_ack;
                s_wr_ack:   if (scl_fall) state_nxt = s_wr;
                s_rd:       if (byte_end) state_nxt = s_rd_ack;
                s_rd_ack:   if (scl_fall) state_nxt = mnack ? s_idle : s_rd;
                default:    state_nxt = s_idle;
            endcase
        end
    end

    // Output logic: next values for SDA drive and strobes
    always_comb begin
        sda_oen_nxt  = sda_oen;
        wr_valid_nxt = 1'b0;
        rd_req_nxt   = 1'b0;
        err_nxt      = 1'b0;
        busy_nxt     = busy;
        load_word    = 1'b0;
        if (!enable || start_det) begin
            sda_oen_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end else if (stop_det) begin
            sda_oen_nxt = 1'b1;
            busy_nxt    = 1'b0;
            // Word cut short: bits pending in the current byte, bytes pending in the word, or ACK not finished
            err_nxt = ((state == s_wr) && ((bit_cnt != 3'd0) || (byte_cnt != 2'd0))) ||
                      (state == s_wr_ack);
        end else begin
            case (state)
                s_addr: if (byte_end && addr_match) begin
                    sda_oen_nxt = ACK;
                    busy_nxt    = 1'b1;
                end
                s_addr_ack: begin
                    if (scl_rise && rw) rd_req_nxt = 1'b1;
                    if (scl_fall) begin
                        if (rw) begin
                            load_word   = 1'b1;
                            sda_oen_nxt = rd_data[WW-1];
                        end else begin
                            sda_oen_nxt = 1'b1;
                        end
                    end
                end
                s_reg, s_wr: if (byte_end) sda_oen_nxt = ACK;
                s_reg_ack:   if (scl_fall) sda_oen_nxt = 1'b1;
                s_wr_ack: begin
                    if (scl_rise && last_data) wr_valid_nxt = 1'b1;
                    if (scl_fall) sda_oen_nxt = 1'b1;
                end
                // tx_sr[WW-1] is the bit on the wire; after the 8th bit release for the master's ACK
                s_rd: if (bit_fall) sda_oen_nxt = (bit_cnt == 3'd7) ? 1'b1 : tx_sr[WW-2];
                s_rd_ack: begin
                    if (scl_rise && (sda_s == ACK) && last_data) rd_req_nxt = 1'b1;
                    if (scl_fall) begin
                        if (mnack) begin
                            sda_oen_nxt = 1'b1;
                        end else if (last_data) begin
                            load_word   = 1'b1;
                            sda_oen_nxt = rd_data[WW-1];
                        end else begin
                            sda_oen_nxt = tx_sr[WW-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_oen  <= 1'b1;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            reg_addr <= '0;
            wr_data  <= '0;
            addr_acc <= '0;
            data_acc <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            bit_seen <= 1'b0;
            rw       <= 1'b0;
            mnack    <= 1'b0;
        end else begin
            sda_oen  <= sda_oen_nxt;
            wr_valid <= wr_valid_nxt;
            rd_req   <= rd_req_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
            if (wr_valid_nxt) wr_data <= data_acc;
            // Post-write increment lands the cycle after the wr_valid pulse
            if (wr_valid) reg_addr <= reg_addr + 1'b1;
            if (!enable || start_det || stop_det) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                bit_seen <= 1'b0;
            end else begin
                if (scl_rise)      bit_seen <= 1'b1;
                else if (scl_fall) bit_seen <= 1'b0;
                if (scl_rise && rx_state) rx_sr <= {rx_sr[6:0], sda_s};
                if (bit_fall && (rx_state || (state == s_rd))) bit_cnt <= bit_cnt + 1'b1;
                if (byte_end) begin
                    case (state)
                        s_addr:  rw       <= rx_sr[0];
                        s_reg:   addr_acc <= (addr_acc << 8) | REG_ADDR_WIDTH'(rx_sr);
                        s_wr:    data_acc <= (data_acc << 8) | WW'(rx_sr);
                        default: ;
                    endcase
                end
                if (bit_fall && (state == s_rd)) tx_sr <= tx_sr << 1;
                if (load_word) tx_sr <= rd_data;
                if (scl_rise) begin
                    case (state)
                        s_reg_ack: if (last_addr) reg_addr <= addr_acc;
                        s_rd_ack: begin
                            mnack <= sda_s;
                            if ((sda_s == ACK) && last_data) reg_addr <= reg_addr + 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        s_addr_ack:         byte_cnt <= '0;
                        s_reg_ack:          byte_cnt <= last_addr ? 2'd0 : byte_cnt + 1'b1;
                        s_wr_ack, s_rd_ack: byte_cnt <= last_data ? 2'd0 : byte_cnt + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  own_addr = 7'h50;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_out, sda_oen;
    logic [7:0]  reg_addr;
    logic [15:0] wr_data;
    logic        wr_valid, rd_req, busy, err;
    logic [15:0] rd_data = 16'h0000;

    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic        oen_low_seen = 1'b0;
    logic [7:0]  wr_addr_log [0:3];
    logic [15:0] wr_dat_log  [0:3];
    logic [7:0]  rd_addr_log = 8'h00;

    i2c_slave #(.ADDR_BYTES(1), .DATA_BYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .own_addr (own_addr),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .sda_oen  (sda_oen),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target
    assign sda_line = sda_m & (sda_oen | sda_out);

    // Strobe logger and register-file read model, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_cnt < 4) begin
                wr_addr_log[wr_cnt] = reg_addr;
                wr_dat_log[wr_cnt]  = wr_data;
            end
            wr_cnt++;
        end
        if (rd_req) begin
            rd_addr_log = reg_addr;
            rd_data     = mem[reg_addr];
            rd_cnt++;
        end
        if (err) err_cnt++;
        if (!sda_oen) oen_low_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0; oen_low_seen = 1'b0;
    endtask

    // START or repeated START (SCL may be high-idle or low)
    task automatic bus_start();
        sda_m = 1'b1; wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        sda_m = 1'b0; wait_clk(8);
        scl_m = 1'b0; wait_clk(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        sda_m = 1'b1; wait_clk(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        scl_m = 1'b0; wait_clk(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(4);
        scl_m = 1'b1; wait_clk(4);
        b = sda_line; wait_clk(4);
        scl_m = 1'b0; wait_clk(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clk(5);
        reset = 1'b1;
        wait_clk(3);
        checks++; if (sda_oen !== 1'b1)     begin failures++; $display("FAIL reset_sda_oen got %b exp 1", sda_oen); end
        checks++; if (sda_out !== 1'b0)     begin failures++; $display("FAIL reset_sda_out got %b exp 0", sda_out); end
        checks++; if (reg_addr !== 8'h00)   begin failures++; $display("FAIL reset_reg_addr got %h exp 00", reg_addr); end
        checks++; if (wr_data !== 16'h0000) begin failures++; $display("FAIL reset_wr_data got %h exp 0000", wr_data); end
        checks++; if (wr_valid !== 1'b0)    begin failures++; $display("FAIL reset_wr_valid got %b exp 0", wr_valid); end
        checks++; if (rd_req !== 1'b0)      begin failures++; $display("FAIL reset_rd_req got %b exp 0", rd_req); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2, a3;
        logic busy_mid;
        clear_logs();
        bus_start();
        write_byte(8'hA0, a0);
        busy_mid = busy;
        write_byte(8'h12, a1);
        write_byte(8'hBE, a2);
        write_byte(8'hEF, a3);
        bus_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL wr_acks got %b exp 0000", {a0, a1, a2, a3}); end
        checks++; if (busy_mid !== 1'b1)  begin failures++; $display("FAIL wr_busy_mid got %b exp 1", busy_mid); end
        checks++; if (wr_cnt !== 1)       begin failures++; $display("FAIL wr_count got %0d exp 1", wr_cnt); end
        checks++; if (wr_dat_log[0] !== 16'hBEEF) begin failures++; $display("FAIL wr_data got %h exp BEEF", wr_dat_log[0]); end
        checks++; if (wr_addr_log[0] !== 8'h12)   begin failures++; $display("FAIL wr_reg_addr got %h exp 12", wr_addr_log[0]); end
        checks++; if (reg_addr !== 8'h13) begin failures++; $display("FAIL wr_addr_incr got %h exp 13", reg_addr); end
        checks++; if (err_cnt !== 0)      begin failures++; $display("FAIL wr_err got %0d exp 0", err_cnt); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL wr_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] hi, lo;
        logic oen_after_nack;
        mem[8'h20] = 16'hA55A;
        clear_logs();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h20, a1);
        bus_start();
        write_byte(8'hA1, a2);
        read_byte(1'b0, hi);
        read_byte(1'b1, lo);
        oen_after_nack = sda_oen;
        bus_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rd_acks got %b exp 000", {a0, a1, a2}); end
        checks++; if (rd_cnt !== 1)          begin failures++; $display("FAIL rd_req_count got %0d exp 1", rd_cnt); end
        checks++; if (rd_addr_log !== 8'h20) begin failures++; $display("FAIL rd_req_addr got %h exp 20", rd_addr_log); end
        checks++; if ({hi, lo} !== 16'hA55A) begin failures++; $display("FAIL rd_word got %h exp A55A", {hi, lo}); end
        checks++; if (oen_after_nack !== 1'b1) begin failures++; $display("FAIL rd_release got %b exp 1", oen_after_nack); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL rd_busy_after got %b exp 0", busy); end
        checks++; if (reg_addr !== 8'h20)    begin failures++; $display("FAIL rd_reg_addr_kept got %h exp 20", reg_addr); end
        checks++; if (wr_cnt !== 0)          begin failures++; $display("FAIL rd_no_wr got %0d exp 0", wr_cnt); end
    endtask

    task automatic test_mismatch();
        logic a0;
        clear_logs();
        bus_start();
        write_byte(8'hA2, a0);
        bus_stop();
        wait_clk(4);
        checks++; if (a0 !== 1'b1)           begin failures++; $display("FAIL mis_ack got %b exp 1", a0); end
        checks++; if (oen_low_seen !== 1'b0) begin failures++; $display("FAIL mis_sda_driven got %b exp 0", oen_low_seen); end
        checks++; if (wr_cnt + rd_cnt !== 0) begin failures++; $display("FAIL mis_strobes got %0d exp 0", wr_cnt + rd_cnt); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL mis_busy got %b exp 0", busy); end
    endtask

    task automatic test_chained_wrap();
        logic a0, a1, a2, a3, a4, a5;
        clear_logs();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h01, a2);
        write_byte(8'h02, a3);
        write_byte(8'h03, a4);
        write_byte(8'h04, a5);
        bus_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b0) begin failures++; $display("FAIL ch_acks got %b exp 000000", {a0, a1, a2, a3, a4, a5}); end
        checks++; if (wr_cnt !== 2)              begin failures++; $display("FAIL ch_count got %0d exp 2", wr_cnt); end
        checks++; if (wr_addr_log[0] !== 8'hFF)  begin failures++; $display("FAIL ch_addr0 got %h exp FF", wr_addr_log[0]); end
        checks++; if (wr_dat_log[0] !== 16'h0102) begin failures++; $display("FAIL ch_data0 got %h exp 0102", wr_dat_log[0]); end
        checks++; if (wr_addr_log[1] !== 8'h00)  begin failures++; $display("FAIL ch_addr1 got %h exp 00", wr_addr_log[1]); end
        checks++; if (wr_dat_log[1] !== 16'h0304) begin failures++; $display("FAIL ch_data1 got %h exp 0304", wr_dat_log[1]); end
        checks++; if (reg_addr !== 8'h01)        begin failures++; $display("FAIL ch_reg_addr got %h exp 01", reg_addr); end
        checks++; if (err_cnt !== 0)             begin failures++; $display("FAIL ch_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_stop_mid_word();
        logic a0, a1, a2;
        clear_logs();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h40, a1);
        write_byte(8'h11, a2);
        bus_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL mid_acks got %b exp 000", {a0, a1, a2}); end
        checks++; if (err_cnt !== 1)      begin failures++; $display("FAIL mid_err_pulses got %0d exp 1", err_cnt); end
        checks++; if (wr_cnt !== 0)       begin failures++; $display("FAIL mid_wr_valid got %0d exp 0", wr_cnt); end
        checks++; if (reg_addr !== 8'h40) begin failures++; $display("FAIL mid_reg_addr got %h exp 40", reg_addr); end
        checks++; if (sda_oen !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle got oen=%b busy=%b exp oen=1 busy=0", sda_oen, busy); end
    endtask

    task automatic test_reset_mid_ack();
        logic a0, a1, a2, a3;
        logic oen_ack, oen_rst;
        clear_logs();
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'hA0 >> i) & 8'h01) != 0);
        wait_clk(2);
        oen_ack = sda_oen;
        #2 reset = 1'b0;
        #1 oen_rst = sda_oen;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(4);
        bus_stop();
        checks++; if (oen_ack !== 1'b0)   begin failures++; $display("FAIL rst_ack_driven got %b exp 0", oen_ack); end
        checks++; if (oen_rst !== 1'b1)   begin failures++; $display("FAIL rst_release got %b exp 1", oen_rst); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL rst_reg_addr got %h exp 00", reg_addr); end
        clear_logs();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h30, a1);
        write_byte(8'h12, a2);
        write_byte(8'h34, a3);
        bus_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL rst_next_acks got %b exp 0000", {a0, a1, a2, a3}); end
        checks++; if (wr_cnt !== 1 || wr_dat_log[0] !== 16'h1234 || wr_addr_log[0] !== 8'h30) begin
            failures++; $display("FAIL rst_next_write got cnt=%0d data=%h addr=%h exp cnt=1 data=1234 addr=30", wr_cnt, wr_dat_log[0], wr_addr_log[0]);
        end
    endtask

    task automatic test_disable();
        logic a0;
        clear_logs();
        enable = 1'b0;
        bus_start();
        write_byte(8'hA0, a0);
        bus_stop();
        enable = 1'b1;
        wait_clk(4);
        checks++; if (a0 !== 1'b1)           begin failures++; $display("FAIL dis_ack got %b exp 1", a0); end
        checks++; if (oen_low_seen !== 1'b0) begin failures++; $display("FAIL dis_sda_driven got %b exp 0", oen_low_seen); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_mismatch();
        test_chained_wrap();
        test_stop_mid_word();
        test_reset_mid_ack();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
